// File: rtl/fir_filter_mac_seq.sv
// fir_filter_mac_seq: time-multiplexed FIR with one multiplier, run-time
// programmable coefficients, valid/ready handshakes on both sides, and a
// rounded/saturated arithmetic-shift output stage.
module fir_filter_mac_seq #(
    parameter  int WIDTH     = 16,
    parameter  int CWIDTH    = 16,
    parameter  int TAPS      = 8,
    parameter  int SHIFT     = 0,
    parameter  int OUT_WIDTH = 20,
    localparam int AW        = $clog2(TAPS),
    localparam int ACC_W     = WIDTH + CWIDTH + AW
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [WIDTH-1:0]     x_in,
    input  logic                        coef_we,
    input  logic [AW-1:0]               coef_addr,
    input  logic signed [CWIDTH-1:0]    coef_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [ACC_W-1:0]     y_out_raw,
    output logic signed [OUT_WIDTH-1:0] y_out,
    output logic                        busy
);

    localparam int PW = WIDTH + CWIDTH;
    localparam int RW = ACC_W + 1;

    localparam logic [AW:0]           KLAST = (AW + 1)'(TAPS);
    localparam logic signed [RW-1:0]  RND   = (SHIFT > 0) ? (RW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
    localparam logic signed [RW-1:0]  MAXV  = {{(RW - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [RW-1:0]  MINV  = {{(RW - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        HOLD
    } state_t;

    state_t                     state;
    logic signed [WIDTH-1:0]    sbuf     [TAPS];
    logic signed [CWIDTH-1:0]   coef_mem [TAPS];
    logic [AW-1:0]              wr_ptr;
    logic [AW:0]                kcnt;
    logic signed [ACC_W-1:0]    acc;
    logic signed [PW-1:0]       prod;

    logic [AW-1:0]              rd_idx;
    logic signed [PW-1:0]       cext;
    logic signed [PW-1:0]       sext;
    logic signed [ACC_W-1:0]    final_sum;
    logic signed [RW-1:0]       rnd;
    logic signed [RW-1:0]       shifted;
    logic signed [OUT_WIDTH-1:0] y_sat;

    // Operand select: tap k pairs coefficient k with the sample k steps older than the newest.
    always_comb begin
        rd_idx = wr_ptr - AW'(1) - kcnt[AW-1:0];
        cext   = PW'(coef_mem[kcnt[AW-1:0]]);
        sext   = PW'(sbuf[rd_idx]);
    end

    // Running sum including the pending product, then round-half-up, shift and clamp.
    always_comb begin
        final_sum = acc + {{AW{prod[PW-1]}}, prod};
        rnd       = {final_sum[ACC_W-1], final_sum} + RND;
        shifted   = rnd >>> SHIFT;
        if (shifted > MAXV)
            y_sat = MAXV[OUT_WIDTH-1:0];
        else if (shifted < MINV)
            y_sat = MINV[OUT_WIDTH-1:0];
        else
            y_sat = shifted[OUT_WIDTH-1:0];
    end

    // Control FSM with datapath registers; product is registered, so the last
    // accumulate happens one cycle after the last multiply (k == TAPS step).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            y_out     <= '0;
            y_out_raw <= '0;
            wr_ptr    <= '0;
            kcnt      <= '0;
            acc       <= '0;
            prod      <= '0;
            for (int unsigned i = 0; i < TAPS; i++) begin
                sbuf[i]     <= '0;
                coef_mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we)
                        coef_mem[coef_addr] <= coef_data;
                    if (in_valid) begin
                        sbuf[wr_ptr] <= x_in;
                        wr_ptr       <= wr_ptr + AW'(1);
                        acc          <= '0;
                        prod         <= '0;
                        kcnt         <= '0;
                        state        <= MAC;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                    end
                end
                MAC: begin
                    if (kcnt == KLAST) begin
                        y_out_raw <= final_sum;
                        y_out     <= y_sat;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        prod <= cext * sext;
                        acc  <= final_sum;
                        kcnt <= kcnt + (AW + 1)'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_mac_seq.sv
// Bench for fir_filter_mac_seq: two instances (SHIFT=0 and SHIFT=2) share
// stimulus; a sample-history model predicts every output each cycle.
module tb_fir_filter_mac_seq;

    localparam int TAPS = 8;
    localparam int OW   = 20;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic signed [15:0]   x_in;
    logic                 coef_we;
    logic [2:0]           coef_addr;
    logic signed [15:0]   coef_data;
    logic                 out_ready;

    logic                 in_ready0, out_valid0, busy0;
    logic signed [34:0]   raw0;
    logic signed [19:0]   y0;
    logic                 in_ready2, out_valid2, busy2;
    logic signed [34:0]   raw2;
    logic signed [19:0]   y2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fir_filter_mac_seq #(.WIDTH(16), .CWIDTH(16), .TAPS(TAPS), .SHIFT(0), .OUT_WIDTH(OW)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid0), .out_ready(out_ready), .y_out_raw(raw0), .y_out(y0), .busy(busy0)
    );

    fir_filter_mac_seq #(.WIDTH(16), .CWIDTH(16), .TAPS(TAPS), .SHIFT(2), .OUT_WIDTH(OW)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid2), .out_ready(out_ready), .y_out_raw(raw2), .y_out(y2), .busy(busy2)
    );

    function automatic void chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Rounded shift with saturation, straight from the arithmetic rule.
    function automatic longint yfun(input longint raw, input int s);
        longint r;
        longint lim;
        r = raw;
        if (s > 0) r = r + (longint'(1) <<< (s - 1));
        r   = r >>> s;
        lim = longint'(1) <<< (OW - 1);
        if (r > lim - 1) r = lim - 1;
        if (r < -lim) r = -lim;
        return r;
    endfunction

    // Model: coefficient table, newest-first history, and protocol timing.
    int     mc [TAPS];
    longint mh [TAPS];
    bit     m_idle  = 1'b1;
    bit     m_valid = 1'b0;
    int     m_wait  = 0;
    longint m_pend  = 0;
    longint m_shown = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                mc[i] = 0;
                mh[i] = 0;
            end
            m_idle = 1'b1; m_valid = 1'b0; m_wait = 0; m_pend = 0; m_shown = 0;
        end else if (m_idle) begin
            if (coef_we) mc[coef_addr] = int'(coef_data);
            if (in_valid) begin
                for (int i = TAPS - 1; i > 0; i--) mh[i] = mh[i-1];
                mh[0]  = longint'(x_in);
                m_pend = 0;
                for (int k = 0; k < TAPS; k++) m_pend += longint'(mc[k]) * mh[k];
                m_idle = 1'b0;
                m_wait = TAPS + 1;
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_shown = m_pend;
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
            m_idle  = 1'b1;
        end
    end

    // Every-cycle compare against the model.
    always @(negedge clk) begin
        chk("in_ready0", longint'(in_ready0), longint'(m_idle));
        chk("in_ready2", longint'(in_ready2), longint'(m_idle));
        chk("busy0", longint'(busy0), longint'(!m_idle));
        chk("out_valid0", longint'(out_valid0), longint'(m_valid));
        chk("out_valid2", longint'(out_valid2), longint'(m_valid));
        chk("raw0", longint'(raw0), m_shown);
        chk("raw2", longint'(raw2), m_shown);
        chk("y0", longint'(y0), yfun(m_shown, 0));
        chk("y2", longint'(y2), yfun(m_shown, 2));
    end

    task automatic wait_idle();
        int n = 0;
        while (!in_ready0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready0) chk("idle_timeout", 0, 1);
    endtask

    task automatic wr_coef(input int a, input int d);
        wait_idle();
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = 16'(d);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic xfer(input longint x, output int lat, output longint r0, output longint v0, output longint v2);
        wait_idle();
        in_valid = 1'b1;
        x_in     = 16'(x);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid0) break;
        end
        if (!out_valid0) chk("valid_timeout", 0, 1);
        r0 = longint'(raw0);
        v0 = longint'(y0);
        v2 = longint'(y2);
    endtask

    initial begin
        #2000000;
        bad++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int     lat;
        longint r0, v0, v2;
        int     ccoef [TAPS];
        int     imp   [9];
        ccoef = '{1, 2, 3, 4, 4, 3, 2, 1};
        imp   = '{100, 200, 300, 400, 400, 300, 200, 100, 0};

        rst = 1'b0; in_valid = 1'b0; x_in = '0; coef_we = 1'b0;
        coef_addr = '0; coef_data = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", longint'(in_ready0), 1);
        chk("rst_busy", longint'(busy0), 0);
        chk("rst_out_valid", longint'(out_valid0), 0);
        chk("rst_raw", longint'(raw0), 0);
        chk("rst_y", longint'(y0), 0);
        rst = 1'b1;
        @(negedge clk);

        // Impulse response and latency
        for (int i = 0; i < TAPS; i++) wr_coef(i, ccoef[i]);
        for (int i = 0; i < 9; i++) begin
            xfer((i == 0) ? 100 : 0, lat, r0, v0, v2);
            chk("imp_y", v0, imp[i]);
            chk("imp_latency", lat, 9);
        end
        chk("imp_y2_last", v2, 0);

        // Step response
        for (int i = 0; i < 10; i++) begin
            xfer(1000, lat, r0, v0, v2);
            if (i == 0) begin
                chk("step_first_y0", v0, 1000);
                chk("step_first_y2", v2, 250);
            end
        end
        chk("step_y0", v0, 20000);
        chk("step_y2", v2, 5000);

        // Saturation
        for (int i = 0; i < TAPS; i++) wr_coef(i, 32767);
        for (int i = 0; i < TAPS; i++) xfer(32767, lat, r0, v0, v2);
        chk("sat_raw", r0, 64'sd8589410312);
        chk("sat_pos_y0", v0, 524287);
        chk("sat_pos_y2", v2, 524287);
        for (int i = 0; i < TAPS; i++) xfer(-32768, lat, r0, v0, v2);
        chk("sat_raw_neg", r0, -64'sd8589672448);
        chk("sat_neg_y0", v0, -524288);
        chk("sat_neg_y2", v2, -524288);

        // Rounding (SHIFT=2 instance)
        wr_coef(0, 1);
        for (int i = 1; i < TAPS; i++) wr_coef(i, 0);
        xfer(6, lat, r0, v0, v2);
        chk("rnd_6", v2, 2);
        xfer(-6, lat, r0, v0, v2);
        chk("rnd_m6", v2, -1);
        xfer(5, lat, r0, v0, v2);
        chk("rnd_5", v2, 1);

        // Backpressure: in_valid and coef_we outside IDLE are ignored
        wait_idle();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        x_in      = 16'sd7;
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'sd50;
        lat = 0;
        while (!out_valid0 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        coef_we = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", longint'(out_valid0), 1);
            chk("bp_in_ready", longint'(in_ready0), 0);
            chk("bp_y0", longint'(y0), 7);
            chk("bp_y2", longint'(y2), 2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", longint'(out_valid0), 0);
        chk("bp_release_ready", longint'(in_ready0), 1);
        xfer(9, lat, r0, v0, v2);
        chk("bp_coef_kept", v0, 9);

        // Reset in the middle of MAC
        for (int i = 0; i < TAPS; i++) wr_coef(i, ccoef[i]);
        wait_idle();
        in_valid = 1'b1;
        x_in     = 16'sd123;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst_out_valid", longint'(out_valid0), 0);
        chk("mrst_in_ready", longint'(in_ready0), 1);
        chk("mrst_busy", longint'(busy0), 0);
        chk("mrst_raw", longint'(raw0), 0);
        chk("mrst_y", longint'(y0), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < TAPS; i++) wr_coef(i, ccoef[i]);
        for (int i = 0; i < 9; i++) begin
            xfer((i == 0) ? 100 : 0, lat, r0, v0, v2);
            chk("post_rst_imp_y", v0, imp[i]);
            chk("post_rst_latency", lat, 9);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
